// File: rtl/inv_rotate_pkg.sv
// Shared constants, state encoding and address helper for the rho-step blocks.
package inv_rotate_pkg;

    localparam int NUM_ROW     = 5;
    localparam int NUM_COLUMN  = 5;
    localparam int NUM_PAGE    = 64;
    localparam int NUM_CELLS   = NUM_ROW * NUM_COLUMN * NUM_PAGE;
    localparam int LEN_ADDRESS = 11;

    typedef logic [2:0] row_t;
    typedef logic [2:0] col_t;
    typedef logic [5:0] page_t;
    typedef logic [LEN_ADDRESS-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flat state index: k*25 + j*5 + i.
    function automatic addr_t cell_addr(input row_t i, input col_t j, input page_t k);
        return addr_t'(k) * addr_t'(NUM_ROW * NUM_COLUMN)
             + addr_t'(j) * addr_t'(NUM_ROW)
             + addr_t'(i);
    endfunction

endpackage

// File: rtl/inv_rotate_rho_offset_rom.sv
// Combinational rho offset table, R[i][j], shared by the forward and inverse rotators.
module rho_offset_rom
    import inv_rotate_pkg::*;
(
    input  row_t  i,
    input  col_t  j,
    output page_t r
);

    // Table lookup keyed on {i, j}; octal literals read directly as "ij".
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        r = '0;
        case ({i, j})
            6'o00: r = 6'd0;
            6'o01: r = 6'd36;
            6'o02: r = 6'd3;
            6'o03: r = 6'd41;
            6'o04: r = 6'd18;
            6'o10: r = 6'd1;
            6'o11: r = 6'd44;
            6'o12: r = 6'd10;
            6'o13: r = 6'd45;
            6'o14: r = 6'd2;
            6'o20: r = 6'd62;
            6'o21: r = 6'd6;
            6'o22: r = 6'd43;
            6'o23: r = 6'd15;
            6'o24: r = 6'd61;
            6'o30: r = 6'd28;
            6'o31: r = 6'd55;
            6'o32: r = 6'd25;
            6'o33: r = 6'd21;
            6'o34: r = 6'd56;
            6'o40: r = 6'd27;
            6'o41: r = 6'd20;
            6'o42: r = 6'd39;
            6'o43: r = 6'd8;
            6'o44: r = 6'd14;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/inv_rotate.sv
// Bit-serial inverse rho: out[i][j][k] = in[i][j][(k + R[i][j]) mod 64], one bit per cycle.
module inv_rotate
    import inv_rotate_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CELLS-1:0] data_out
);

    state_t               state;
    state_t               state_next;
    logic [NUM_CELLS-1:0] capture;
    row_t                 i_cnt;
    col_t                 j_cnt;
    page_t                k_cnt;
    page_t                rho;
    page_t                kk;
    logic                 i_wrap;
    logic                 j_wrap;
    logic                 k_wrap;
    logic                 accept;
    logic                 run;
    addr_t                src_addr;
    addr_t                dst_addr;
    logic                 src_bit;

    rho_offset_rom u_rho_offset_rom (
        .i (i_cnt),
        .j (j_cnt),
        .r (rho)
    );

    // Counter chain and bit select: i enables j on wrap, j enables k; kk wraps mod 64 in 6 bits.
    always_comb begin
        i_wrap   = (i_cnt == row_t'(NUM_ROW - 1));
        j_wrap   = (j_cnt == col_t'(NUM_COLUMN - 1));
        k_wrap   = (k_cnt == page_t'(NUM_PAGE - 1));
        accept   = (state == ST_IDLE) && start;
        run      = (state == ST_RUN);
        kk       = k_cnt + rho;
        src_addr = cell_addr(i_cnt, j_cnt, kk);
        dst_addr = cell_addr(i_cnt, j_cnt, k_cnt);
        src_bit  = capture[src_addr];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments to avoid simulation races.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (i_wrap && j_wrap && k_wrap) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the input state on an accepted start; data_in is free to change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            capture <= '0;
        end else if (accept) begin
            capture <= data_in;
        end
    end

    // Position counters: cleared on accept, stepped once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (run) begin
            i_cnt <= i_wrap ? '0 : i_cnt + 3'd1;
            if (i_wrap) begin
                j_cnt <= j_wrap ? '0 : j_cnt + 3'd1;
                if (j_wrap) begin
                    k_cnt <= k_cnt + 6'd1;
                end
            end
        end
    end

    // Result store: one bit written per RUN cycle, driven straight to data_out.
    always_ff @(posedge clk) begin
        // NOTE: the store is reset explicitly so an aborted result never leaks out after rst.
        if (rst) begin
            data_out <= '0;
        end else if (run) begin
            data_out[dst_addr] <= src_bit;
        end
    end

endmodule

// File: tb/tb_inv_rotate.sv
// Directed self-checking bench for inv_rotate.
module tb_inv_rotate;

    localparam int CELLS = 1600;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CELLS-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CELLS-1:0] data_out;

    int tests;
    int fails;

    int rtab [0:24] = '{0, 36, 3, 41, 18,
                        1, 44, 10, 45, 2,
                        62, 6, 43, 15, 61,
                        28, 55, 25, 21, 56,
                        27, 20, 39, 8, 14};

    inv_rotate dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
        int ndiff;
        int first;
        ndiff = 0;
        first = -1;
        for (int b = 0; b < CELLS; b++) begin
            if (obs[b] !== exp[b]) begin
                ndiff++;
                if (first < 0) first = b;
            end
        end
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: %0d bits differ, first at %0d (got %b expected %b)",
                   tag, ndiff, first, obs[first], exp[first]);
        end
    endtask

    function automatic logic [CELLS-1:0] rho_inv(input logic [CELLS-1:0] s);
        logic [CELLS-1:0] o;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < 64; k++)
                    o[k*25 + j*5 + i] = s[((k + rtab[i*5 + j]) % 64)*25 + j*5 + i];
        return o;
    endfunction

    function automatic logic [CELLS-1:0] rho_fwd(input logic [CELLS-1:0] s);
        logic [CELLS-1:0] o;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < 64; k++)
                    o[((k + rtab[i*5 + j]) % 64)*25 + j*5 + i] = s[k*25 + j*5 + i];
        return o;
    endfunction

    task automatic rand_state(output logic [CELLS-1:0] s);
        for (int w = 0; w < CELLS/32; w++) s[w*32 +: 32] = $urandom;
    endtask

    // Starts an operation and returns in the cycle where done is seen; lat = cycle number.
    task automatic run_op(input logic [CELLS-1:0] d, input bit repulse, output int lat);
        data_in = d;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("busy_cycle1", busy, 1);
        lat = 1;
        while (done !== 1'b1 && lat < 1700) begin
            tick();
            lat++;
            if (repulse && lat == 100) begin
                start = 1'b1;
                tick();
                lat++;
                start = 1'b0;
                check("busy_after_repulse", busy, 1);
            end
        end
    endtask

    task automatic finish_op();
        tick();
        check("done_pulse_low", done, 0);
        check("busy_idle", busy, 0);
    endtask

    logic [CELLS-1:0] vec;
    logic [CELLS-1:0] exp_vec;
    logic [CELLS-1:0] vec_b;
    logic [CELLS-1:0] mask;
    int               lat;
    int               n;

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_state("rst_data_out", data_out, '0);
        rst = 1'b0;
        tick();

        // Single bit at index 5 (i=0,j=1,k=0), R=36 -> index 705 (k=28).
        vec = '0; vec[5] = 1'b1;
        exp_vec = '0; exp_vec[705] = 1'b1;
        run_op(vec, 1'b0, lat);
        check("latency_bit5", lat, 1601);
        check("done_bit5", done, 1);
        check("busy_at_done", busy, 0);
        check_state("single_bit5", data_out, exp_vec);
        finish_op();
        check_state("stable_after_done", data_out, exp_vec);

        // Wrap: index 349 (i=4,j=4,k=13), R=14 -> index 1599 (k=63).
        vec = '0; vec[349] = 1'b1;
        exp_vec = '0; exp_vec[1599] = 1'b1;
        run_op(vec, 1'b0, lat);
        check("latency_wrap", lat, 1601);
        check_state("wrap_bit349", data_out, exp_vec);
        finish_op();

        // All ones and all zeros are invariant.
        run_op({CELLS{1'b1}}, 1'b0, lat);
        check_state("all_ones", data_out, {CELLS{1'b1}});
        finish_op();
        run_op('0, 1'b0, lat);
        check_state("all_zeros", data_out, '0);
        finish_op();

        // R[0][0]=0 lane passes through unchanged; whole result against the model.
        rand_state(vec);
        mask = '0;
        for (int k = 0; k < 64; k++) mask[k*25] = 1'b1;
        run_op(vec, 1'b0, lat);
        check_state("lane00_passthru", data_out & mask, vec & mask);
        check_state("random_model", data_out, rho_inv(vec));
        finish_op();

        // Round trip through a forward rotate; first run re-pulses start mid-RUN.
        for (int s = 0; s < 20; s++) begin
            rand_state(vec);
            run_op(rho_fwd(vec), (s == 0), lat);
            check("rt_latency", lat, 1601);
            check_state("round_trip", data_out, vec);
            finish_op();
        end

        // Reset at cycle 800 of RUN aborts and clears the store.
        rand_state(vec);
        data_in = vec;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (799) tick();
        check("busy_cycle800", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_state("abort_cleared", data_out, '0);
        vec = '0; vec[349] = 1'b1;
        exp_vec = '0; exp_vec[1599] = 1'b1;
        run_op(vec, 1'b0, lat);
        check("post_abort_latency", lat, 1601);
        check_state("post_abort_result", data_out, exp_vec);
        finish_op();

        // start held high: back-to-back, done at 1601 and 3203; data_in change on cycle 1 ignored.
        rand_state(vec);
        rand_state(vec_b);
        data_in = vec;
        start   = 1'b1;
        tick();
        data_in = vec_b;
        lat = 1;
        while (done !== 1'b1 && lat < 1700) begin
            tick();
            lat++;
        end
        check("held_first_done", lat, 1601);
        check_state("held_first_result", data_out, rho_inv(vec));
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 1700);
        check("held_second_done", lat + n, 3203);
        check_state("held_second_result", data_out, rho_inv(vec_b));
        start = 1'b0;
        tick();
        check("held_done_low", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
